booth_product_accumulator: RTL and testbench
============================================

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

Interface
REQ-001 SHALL provide parameter: ACC_W, 16, accumulator/result width in bits (legal range 8..32).
REQ-002 SHALL provide parameter: LEN, 4, number of products summed per frame (legal range 1..255).
REQ-003 SHALL provide port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port: clear  input  1  synchronous frame abort.
REQ-006 SHALL provide port: prod_valid  input  1  upstream product present.
REQ-007 SHALL provide port: prod_data  input  8  signed 8-bit product from the Booth multiplier stage.
REQ-008 SHALL provide port: prod_ready  output  1  block accepts prod_data this cycle.
REQ-009 SHALL provide port: sum_valid  output  1  frame result present.
REQ-010 SHALL provide port: sum_ready  input  1  downstream accepts result.
REQ-011 SHALL provide port: sum_data  output  ACC_W  signed frame sum.
REQ-012 SHALL provide port: sum_ovf  output  1  frame overflowed ACC_W signed range.
REQ-013 SHALL provide port: count  output  8  products accepted in current frame.

Function
REQ-014 SHALL implement a two-state FSM: ACC (collect) and HOLD (present result).
REQ-015 SHALL drive prod_ready=1 in ACC and 0 in HOLD, combinationally from state only.
REQ-016 SHALL, on an accept (prod_valid & prod_ready) in ACC, add sign-extended prod_data to the accumulator and increment count.
REQ-017 SHALL, on the accept where count==LEN-1, load sum_data with the final sum, assert sum_valid, and enter HOLD on the next edge (latency: sum_valid high 1 cycle after last accept).
REQ-018 SHALL hold sum_data, sum_ovf and sum_valid stable in HOLD while sum_ready is 0.
REQ-019 SHALL, in HOLD with sum_ready=1, deassert sum_valid, zero accumulator, count and sum_ovf, and return to ACC on the next edge; no product is accepted in that cycle.
REQ-020 SHALL ignore prod_data and prod_valid when no accept occurs; gaps in prod_valid do not affect count.
REQ-021 SHALL detect signed overflow per addition (operands same sign, result sign differs) and set a sticky frame flag presented as sum_ovf with the result.
REQ-022 SHALL, when clear=1 (and rst=0), zero accumulator, count, sum_ovf, deassert sum_valid and enter ACC; a product offered that cycle is discarded; a pending HOLD result is dropped.
REQ-023 SHALL keep sum_data at its last value when sum_valid=0 (not a defined result).
REQ-024 SHALL treat LEN=1 as: every accepted product produces a result.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter ACC with accumulator=0, count=0, sum_data=0, sum_valid=0, sum_ovf=0; rst overrides clear and all handshakes, including mid-frame and in HOLD.
REQ-026 SHALL drive prod_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL use macro BOOTH_ACC_SATURATE_EN: defined -> on overflow the accumulator clamps to max positive (2^(ACC_W-1)-1) or min negative (-2^(ACC_W-1)) and stays clamped-consistent for further adds; undefined -> two's-complement wrap. sum_ovf behaves identically in both builds.

Verification
REQ-028 SHALL cover: ACC_W=16, LEN=4, products 12, -6, 64, -56 back-to-back, sum_ready=1 -> sum_data=0x000E, sum_ovf=0, sum_valid high exactly 1 cycle after 4th accept.
REQ-029 SHALL cover: same frame, sum_ready held 0 for 3 cycles -> sum_data=0x000E stable, prod_ready=0 throughout, next frame starts count=0 after handshake.
REQ-030 SHALL cover: ACC_W=8, LEN=2, products 100, 100 -> undefined macro: sum_data=0xC8, sum_ovf=1; macro defined: sum_data=0x7F, sum_ovf=1.
REQ-031 SHALL cover: LEN=4, accept 5, 7, then clear=1, then four products of 1 -> sum_data=0x0004, count sequence restarts at 0.
REQ-032 SHALL cover: rst=1 while in HOLD with sum_ready=0 -> next cycle sum_valid=0, sum_data=0, prod_ready=1.
REQ-033 SHALL cover: prod_valid toggling 1,0,0,1,0,1,1 with values -8, x, x, -8, x, 4, 4 (LEN=4) -> sum_data=0xFFF8 (-8).

Source files
------------

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums LEN signed 8-bit products per frame into an ACC_W-bit result.
// Define BOOTH_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [7:0]       prod_data,
  output logic             prod_ready,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_data,
  output logic             sum_ovf,
  output logic [7:0]       count
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc, ext, raw, nxt;
  logic [7:0] cnt;
  logic ovf, o, accept, last, done;
  always_comb begin
    ext = ACC_W'($signed(prod_data));
    raw = acc + ext;
    o = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
    nxt = !o ? raw : ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    nxt = raw;
`endif
  end
  assign prod_ready = state == ACC;
  assign sum_valid  = state == HOLD;
  assign accept     = prod_valid && prod_ready;
  assign last       = cnt == 8'(LEN - 1);
  assign done       = state == HOLD && sum_ready;
  assign sum_ovf    = ovf;
  assign count      = cnt;
  always_comb begin
    state_n = state;
    if (accept && last) state_n = HOLD;
    if (done) state_n = ACC;
  end
  always_ff @(posedge clk)
    state <= (rst || clear) ? ACC : state_n;
  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= nxt;
      cnt <= cnt + 8'd1;
      ovf <= ovf | o;
    end
    if (rst) sum_data <= '0;
    else if (!clear && accept && last) sum_data <= nxt;
  end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: directed vector table, corner sequences and randomized model check.
module tb_booth_product_accumulator;
  logic clk = 0, rst = 1;
  logic clear = 0, prod_valid = 0, sum_ready = 0;
  logic [7:0] prod_data = 0;
  logic prod_ready, sum_valid, sum_ovf;
  logic [15:0] sum_data;
  logic [7:0] count;
  logic clear1 = 0, prod_valid1 = 0, sum_ready1 = 0;
  logic [7:0] prod_data1 = 0;
  logic prod_ready1, sum_valid1, sum_ovf1;
  logic [7:0] sum_data1, count1;
  int total = 0, passed = 0;

  booth_product_accumulator #(.ACC_W(16), .LEN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_ovf(sum_ovf), .count(count));

  booth_product_accumulator #(.ACC_W(8), .LEN(2)) dut8 (
    .clk(clk), .rst(rst), .clear(clear1), .prod_valid(prod_valid1), .prod_data(prod_data1),
    .prod_ready(prod_ready1), .sum_valid(sum_valid1), .sum_ready(sum_ready1),
    .sum_data(sum_data1), .sum_ovf(sum_ovf1), .count(count1));

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [7:0] d; logic sr; logic clr;
    logic ev; logic [15:0] ed; logic [7:0] ec;
  } vec_t;
  vec_t tbl[29];
  int n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(logic v, int d, logic sr, logic clr, logic ev, int ed, int ec);
    tbl[n] = '{v, 8'(d), sr, clr, ev, 16'(ed), 8'(ec)};
    n++;
  endfunction

  int macc, mn, mp;
  logic mhold, movf, mrovf;
  logic [15:0] mres;

  function automatic void madd(int p);
    int t;
    t = macc + p;
    if (t > 32767 || t < -32768) begin
      movf = 1;
`ifdef BOOTH_ACC_SATURATE_EN
      t = (t > 32767) ? 32767 : -32768;
`else
      t = (t > 32767) ? t - 65536 : t + 65536;
`endif
    end
    macc = t;
  endfunction

  initial begin
    add(1, 12, 1, 0, 0, 0, 1);   add(1, -6, 1, 0, 0, 0, 2);
    add(1, 64, 1, 0, 0, 0, 3);   add(1, -56, 0, 0, 1, 'h000E, 4);
    add(1, 99, 0, 0, 1, 'h000E, 4); add(1, 99, 0, 0, 1, 'h000E, 4);
    add(1, 99, 0, 0, 1, 'h000E, 4); add(0, 0, 1, 0, 0, 0, 0);
    add(1, 12, 1, 0, 0, 0, 1);   add(1, -6, 1, 0, 0, 0, 2);
    add(1, 64, 1, 0, 0, 0, 3);   add(1, -56, 1, 0, 1, 'h000E, 4);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, -8, 1, 0, 0, 0, 1);   add(0, 55, 1, 0, 0, 0, 1);
    add(0, 55, 1, 0, 0, 0, 1);   add(1, -8, 1, 0, 0, 0, 2);
    add(0, 3, 1, 0, 0, 0, 2);    add(1, 4, 1, 0, 0, 0, 3);
    add(1, 4, 1, 0, 1, 'hFFF8, 4); add(0, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 0, 0, 0, 1);    add(1, 7, 1, 0, 0, 0, 2);
    add(1, 9, 1, 1, 0, 0, 0);    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 2);    add(1, 1, 1, 0, 0, 0, 3);
    add(1, 1, 1, 0, 1, 'h0004, 4); add(0, 0, 1, 0, 0, 0, 0);

    tick(); tick();
    rst = 0;
    chk("reset_valid", sum_valid, 0);
    chk("reset_data", sum_data, 0);
    chk("reset_ovf", sum_ovf, 0);
    chk("reset_count", count, 0);
    chk("reset_ready", prod_ready, 1);

    for (int i = 0; i < n; i++) begin
      prod_valid = tbl[i].v; prod_data = tbl[i].d; sum_ready = tbl[i].sr; clear = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), sum_valid, tbl[i].ev);
      chk($sformatf("vec%0d_ready", i), prod_ready, !tbl[i].ev);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), sum_data, tbl[i].ed);
        chk($sformatf("vec%0d_ovf", i), sum_ovf, 0);
      end
    end
    clear = 0;

    sum_ready = 0; prod_valid = 1; prod_data = 8'd3;
    repeat (4) tick();
    prod_valid = 0;
    chk("hold_before_rst", sum_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_hold_valid", sum_valid, 0);
    chk("rst_hold_data", sum_data, 0);
    chk("rst_hold_ready", prod_ready, 1);

    prod_valid1 = 1; prod_data1 = 8'd100;
    tick(); tick();
    prod_valid1 = 0;
    chk("w8_valid", sum_valid1, 1);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("w8_data", sum_data1, 8'h7F);
`else
    chk("w8_data", sum_data1, 8'hC8);
`endif
    chk("w8_ovf", sum_ovf1, 1);
    sum_ready1 = 1;
    tick();
    chk("w8_release_valid", sum_valid1, 0);
    chk("w8_release_ovf", sum_ovf1, 0);
    prod_valid1 = 1; prod_data1 = 8'h80;
    tick(); tick();
    prod_valid1 = 0;
`ifdef BOOTH_ACC_SATURATE_EN
    chk("w8_neg_data", sum_data1, 8'h80);
`else
    chk("w8_neg_data", sum_data1, 8'h00);
`endif
    chk("w8_neg_ovf", sum_ovf1, 1);

    macc = 0; mn = 0; mhold = 0; movf = 0; mres = 0; mrovf = 0;
    for (int c = 0; c < 400; c++) begin
      prod_valid = ($urandom % 4) != 0;
      prod_data = 8'($urandom);
      sum_ready = ($urandom % 3) != 0;
      clear = ($urandom % 50) == 0;
      if (clear) begin
        macc = 0; mn = 0; movf = 0; mhold = 0;
      end else if (mhold) begin
        if (sum_ready) begin
          macc = 0; mn = 0; movf = 0; mhold = 0;
        end
      end else if (prod_valid) begin
        mp = int'($signed(prod_data));
        madd(mp);
        mn++;
        if (mn == 4) begin
          mhold = 1; mres = 16'(macc); mrovf = movf;
        end
      end
      tick();
      chk("rnd_valid", sum_valid, mhold);
      chk("rnd_count", count, 8'(mn));
      if (mhold) begin
        chk("rnd_data", sum_data, mres);
        chk("rnd_ovf", sum_ovf, mrovf);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
